// File: rtl/brt_usb_ss_link_sched.sv
// brt_usb_ss_link_sched
// Sequences the host/device pass-through of the USB SS serial test harness.
// It powers VBUS first, then looks for SuperSpeed Rx terminations on both
// sides. Each detect attempt is bounded by a timeout, and the block falls back
// to the USB 2.0 HS path after MAX_ATTEMPTS failed attempts. Tests can force a
// disconnect/reconnect cycle.
//
// Ports
//   clk                        harness clock
//   rst                        synchronous reset, active-high, highest priority
//   enable                     link enable; 0 forces OFF
//   force_disc                 single-cycle disconnect request
//   vip_ss_termination_host    host VIP SS Rx termination present
//   vip_ss_termination_device  device VIP SS Rx termination present
//   vip_hs_termination_host    host VIP HS termination present
//   vip_hs_termination_device  device VIP HS termination present
//   vbus_en                    connect VBUS between host and device
//   ss_lane_en                 pass SS lanes (0 = electrical idle)
//   hs_path_en                 pass HS terminations and D+/D-
//   link_state                 encoded FSM state
//   ss_up                      one-cycle pulse on entry to SS_ACTIVE
//   attempt_cnt                failed SS detect attempts since last VBUS_WAIT
//   disc_cnt                   completed disconnects, saturating at 255
//
// state          | meaning
// ---------------+--------------------------------------------------------
// OFF        (0) | everything disconnected, waiting for enable
// VBUS_WAIT  (1) | VBUS on, settling for VBUS_DLY cycles
// SS_DETECT  (2) | VBUS on, looking for debounced SS terminations on both sides
// SS_ACTIVE  (3) | SS lanes passed through
// HS_ACTIVE  (4) | HS fallback path passed through
// DISCONNECT (5) | VBUS off for DISC_CYCLES, then reconnect

module brt_usb_ss_link_sched #(
  parameter int VBUS_DLY     = 16,
  parameter int DEBOUNCE     = 8,
  parameter int DET_TIMEOUT  = 1024,
  parameter int MAX_ATTEMPTS = 3,
  parameter int DISC_CYCLES  = 64,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       force_disc,
  input  logic       vip_ss_termination_host,
  input  logic       vip_ss_termination_device,
  input  logic       vip_hs_termination_host,
  input  logic       vip_hs_termination_device,
  output logic       vbus_en,
  output logic       ss_lane_en,
  output logic       hs_path_en,
  output logic [2:0] link_state,
  output logic       ss_up,
  output logic [3:0] attempt_cnt,
  output logic [7:0] disc_cnt
);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_VBUS_WAIT  = 3'd1,
    ST_SS_DETECT  = 3'd2,
    ST_SS_ACTIVE  = 3'd3,
    ST_HS_ACTIVE  = 3'd4,
    ST_DISCONNECT = 3'd5
  } state_t;

  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam logic [CW-1:0] T_VBUS_LAST = CW'(VBUS_DLY - 1);
  localparam logic [CW-1:0] T_DET_LAST  = CW'(DET_TIMEOUT - 1);
  localparam logic [CW-1:0] T_DISC_LAST = CW'(DISC_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [3:0]    ATT_MAX     = 4'(MAX_ATTEMPTS);

  state_t        r_state;
  logic [CW-1:0] r_timer;
  logic [DW-1:0] r_deb;

  state_t        w_nxt;
  logic          w_enter;
  logic          w_att_inc;
  logic          w_disc_inc;
  logic          w_ss_both;
  logic          w_hs_both;
  logic          w_deb_cond;
  logic          w_deb_done;
  logic [3:0]    w_att_plus;

  assign w_ss_both  = vip_ss_termination_host & vip_ss_termination_device;
  assign w_hs_both  = vip_hs_termination_host & vip_hs_termination_device;
  assign w_att_plus = attempt_cnt + 4'd1;

  // One debounce counter serves every state: only the condition it watches
  // changes with the state.
  always_comb begin
    w_deb_cond = 1'b0;
    case (r_state)
      ST_SS_DETECT: w_deb_cond = w_ss_both;
      ST_SS_ACTIVE: w_deb_cond = ~w_ss_both;
      ST_HS_ACTIVE: w_deb_cond = ~w_hs_both;
      default:      w_deb_cond = 1'b0;
    endcase
  end

  assign w_deb_done = w_deb_cond && (r_deb == DEB_LAST);

  // w_enter marks every state entry, including re-entry of SS_DETECT after a
  // timed-out attempt and DISCONNECT restarting on a repeated force_disc.
  always_comb begin
    w_nxt      = r_state;
    w_enter    = 1'b0;
    w_att_inc  = 1'b0;
    w_disc_inc = 1'b0;
    if (r_state > ST_DISCONNECT) begin
      w_nxt   = ST_OFF;
      w_enter = 1'b1;
    end else if (!enable) begin
      w_nxt   = ST_OFF;
      w_enter = (r_state != ST_OFF);
    end else if (force_disc && (r_state != ST_OFF)) begin
      w_nxt   = ST_DISCONNECT;
      w_enter = 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_nxt   = ST_VBUS_WAIT;
          w_enter = 1'b1;
        end
        ST_VBUS_WAIT: begin
          if (r_timer == T_VBUS_LAST) begin
            w_nxt   = ST_SS_DETECT;
            w_enter = 1'b1;
          end
        end
        ST_SS_DETECT: begin
          // A debounce that completes on the timeout cycle counts as success.
          if (w_deb_done) begin
            w_nxt   = ST_SS_ACTIVE;
            w_enter = 1'b1;
          end else if (r_timer == T_DET_LAST) begin
            w_att_inc = 1'b1;
            w_enter   = 1'b1;
            w_nxt     = (w_att_plus == ATT_MAX) ? ST_HS_ACTIVE : ST_SS_DETECT;
          end
        end
        ST_SS_ACTIVE: begin
          if (w_deb_done) begin
            w_nxt   = ST_SS_DETECT;
            w_enter = 1'b1;
          end
        end
        ST_HS_ACTIVE: begin
          if (w_deb_done) begin
            w_nxt   = ST_DISCONNECT;
            w_enter = 1'b1;
          end
        end
        ST_DISCONNECT: begin
          if (r_timer == T_DISC_LAST) begin
            w_nxt      = ST_VBUS_WAIT;
            w_enter    = 1'b1;
            w_disc_inc = 1'b1;
          end
        end
        default: begin
          w_nxt   = ST_OFF;
          w_enter = 1'b1;
        end
      endcase
    end
  end

  // Outputs decode the next state so that they are valid on the first cycle
  // of each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_OFF;
      r_timer     <= '0;
      r_deb       <= '0;
      vbus_en     <= 1'b0;
      ss_lane_en  <= 1'b0;
      hs_path_en  <= 1'b0;
      link_state  <= 3'd0;
      ss_up       <= 1'b0;
      attempt_cnt <= 4'd0;
      disc_cnt    <= 8'd0;
    end else begin
      r_state <= w_nxt;

      if (w_enter)
        r_timer <= '0;
      else if (r_timer != '1)
        r_timer <= r_timer + 1'b1;

      if (w_enter || !w_deb_cond)
        r_deb <= '0;
      else
        r_deb <= r_deb + 1'b1;

      if (w_enter && (w_nxt == ST_VBUS_WAIT))
        attempt_cnt <= 4'd0;
      else if (w_att_inc)
        attempt_cnt <= w_att_plus;

      if (w_disc_inc && (disc_cnt != 8'hFF))
        disc_cnt <= disc_cnt + 8'd1;

      link_state <= w_nxt;
      vbus_en    <= (w_nxt == ST_VBUS_WAIT) || (w_nxt == ST_SS_DETECT) ||
                    (w_nxt == ST_SS_ACTIVE) || (w_nxt == ST_HS_ACTIVE);
      ss_lane_en <= (w_nxt == ST_SS_ACTIVE);
      hs_path_en <= (w_nxt == ST_HS_ACTIVE);
      ss_up      <= (w_nxt == ST_SS_ACTIVE) && (r_state != ST_SS_ACTIVE);
    end
  end

endmodule

// File: tb/tb_brt_usb_ss_link_sched.sv
// Directed testbench for brt_usb_ss_link_sched. It uses short parameters:
// VBUS_DLY=4, DEBOUNCE=3, DET_TIMEOUT=20, MAX_ATTEMPTS=2, DISC_CYCLES=5.
// Each table record drives its inputs, advances n clocks and then compares
// the whole output bundle. Hand-written sequences cover the timeout/debounce
// tie and a reset during SS_DETECT.
// term field bit order: {ss_host, ss_device, hs_host, hs_device}.

module tb_brt_usb_ss_link_sched;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       force_disc;
  logic       ss_h, ss_d, hs_h, hs_d;
  logic       vbus_en, ss_lane_en, hs_path_en, ss_up;
  logic [2:0] link_state;
  logic [3:0] attempt_cnt;
  logic [7:0] disc_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  brt_usb_ss_link_sched #(
    .VBUS_DLY(4), .DEBOUNCE(3), .DET_TIMEOUT(20),
    .MAX_ATTEMPTS(2), .DISC_CYCLES(5), .CW(16)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .enable                    (enable),
    .force_disc                (force_disc),
    .vip_ss_termination_host   (ss_h),
    .vip_ss_termination_device (ss_d),
    .vip_hs_termination_host   (hs_h),
    .vip_hs_termination_device (hs_d),
    .vbus_en                   (vbus_en),
    .ss_lane_en                (ss_lane_en),
    .hs_path_en                (hs_path_en),
    .link_state                (link_state),
    .ss_up                     (ss_up),
    .attempt_cnt               (attempt_cnt),
    .disc_cnt                  (disc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, fd;
    logic [3:0] term;
    int         n;
    logic [2:0] st;
    logic       vb, ss, hs, up;
    logic [3:0] att;
    logic [7:0] dc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, en, fd, input logic [3:0] term, input int n,
                     input logic [2:0] st, input logic vb, ss, hs, up,
                     input logic [3:0] att, input logic [7:0] dc);
    vec_t v;
    v.rst = r; v.en = en; v.fd = fd; v.term = term; v.n = n;
    v.st = st; v.vb = vb; v.ss = ss; v.hs = hs; v.up = up; v.att = att; v.dc = dc;
    tbl.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic r, en, fd, input logic [3:0] term);
    rst = r; enable = en; force_disc = fd;
    {ss_h, ss_d, hs_h, hs_d} = term;
  endtask

  task automatic check(input string nm, input logic [2:0] st, input logic vb, ss, hs, up,
                       input logic [3:0] att, input logic [7:0] dc);
    logic [18:0] act, exp;
    act = {link_state, vbus_en, ss_lane_en, hs_path_en, ss_up, attempt_cnt, disc_cnt};
    exp = {st, vb, ss, hs, up, att, dc};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got st=%0d vbus=%b ss=%b hs=%b up=%b att=%0d disc=%0d, want st=%0d vbus=%b ss=%b hs=%b up=%b att=%0d disc=%0d",
               nm, link_state, vbus_en, ss_lane_en, hs_path_en, ss_up, attempt_cnt, disc_cnt,
               st, vb, ss, hs, up, att, dc);
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'b0000);

    //  rst en fd term  n   st vb ss hs up att dc
    add(1, 0, 0, 4'b0000, 2, 0, 0, 0, 0, 0, 0, 0);  // reset state
    // SS bring-up
    add(0, 1, 0, 4'b1111, 1, 1, 1, 0, 0, 0, 0, 0);  // cycle 1: VBUS_WAIT
    add(0, 1, 0, 4'b1111, 3, 1, 1, 0, 0, 0, 0, 0);  // cycle 4: still waiting
    add(0, 1, 0, 4'b1111, 1, 2, 1, 0, 0, 0, 0, 0);  // cycle 5: SS_DETECT
    add(0, 1, 0, 4'b1111, 2, 2, 1, 0, 0, 0, 0, 0);  // cycle 7
    add(0, 1, 0, 4'b1111, 1, 3, 1, 1, 0, 1, 0, 0);  // cycle 8: SS_ACTIVE + ss_up
    add(0, 1, 0, 4'b1111, 1, 3, 1, 1, 0, 0, 0, 0);  // pulse gone
    // SS termination glitches
    add(0, 1, 0, 4'b0111, 2, 3, 1, 1, 0, 0, 0, 0);  // 2-cycle drop: stay
    add(0, 1, 0, 4'b1111, 1, 3, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0111, 2, 3, 1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 4'b0111, 1, 2, 1, 0, 0, 0, 0, 0);  // 3rd low cycle: back to detect
    add(0, 1, 0, 4'b1111, 2, 2, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 1, 3, 1, 1, 0, 1, 0, 0);  // re-detected
    // forced disconnect
    add(0, 1, 1, 4'b1111, 1, 5, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 4, 5, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4'b1111, 1, 1, 1, 0, 0, 0, 0, 1);  // 5 cycles: disc_cnt=1
    add(0, 1, 0, 4'b1111, 4, 2, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4'b1111, 3, 3, 1, 1, 0, 1, 0, 1);
    // force_disc during DISCONNECT restarts the hold-off
    add(0, 1, 1, 4'b1111, 1, 5, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4'b1111, 3, 5, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 4'b1111, 1, 5, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4'b1111, 4, 5, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4'b1111, 1, 1, 1, 0, 0, 0, 0, 2);
    // enable=0 beats force_disc
    add(0, 0, 1, 4'b1111, 1, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 4'b1111, 3, 0, 0, 0, 0, 0, 0, 2);
    // HS fallback: device SS termination never present
    add(0, 1, 0, 4'b1011, 1, 1, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 4'b1011, 4, 2, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 4'b1011, 19, 2, 1, 0, 0, 0, 0, 2); // last cycle of attempt 1
    add(0, 1, 0, 4'b1011, 1, 2, 1, 0, 0, 0, 1, 2);  // attempt 2
    add(0, 1, 0, 4'b1011, 19, 2, 1, 0, 0, 0, 1, 2);
    add(0, 1, 0, 4'b1011, 1, 4, 1, 0, 1, 0, 2, 2);  // HS_ACTIVE
    // HS termination glitches
    add(0, 1, 0, 4'b1010, 2, 4, 1, 0, 1, 0, 2, 2);
    add(0, 1, 0, 4'b1011, 1, 4, 1, 0, 1, 0, 2, 2);
    add(0, 1, 0, 4'b1010, 3, 5, 0, 0, 0, 0, 2, 2);  // HS lost: disconnect
    add(0, 1, 0, 4'b1011, 5, 1, 1, 0, 0, 0, 0, 3);  // reconnect clears attempts

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].fd, tbl[i].term);
      step(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].vb, tbl[i].ss, tbl[i].hs,
            tbl[i].up, tbl[i].att, tbl[i].dc);
    end

    // Debounce completes on the timeout cycle of attempt 2: success wins.
    drive(1'b1, 1'b1, 1'b0, 4'b1011);
    step(1);
    check("rst_clear", 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 4'b1011);
    step(42);
    check("tie_pre", 2, 1, 0, 0, 0, 1, 0);
    drive(1'b0, 1'b1, 1'b0, 4'b1111);
    step(2);
    check("tie_deb", 2, 1, 0, 0, 0, 1, 0);
    step(1);
    check("tie_win", 3, 1, 1, 0, 1, 1, 0);
    step(1);
    check("tie_hold", 3, 1, 1, 0, 0, 1, 0);

    // Reset while in SS_DETECT.
    drive(1'b0, 1'b1, 1'b0, 4'b0111);
    step(3);
    check("to_detect", 2, 1, 0, 0, 0, 1, 0);
    drive(1'b1, 1'b1, 1'b0, 4'b0111);
    step(1);
    check("rst_mid_detect", 0, 0, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 4'b0111);
    step(1);
    check("post_rst", 1, 1, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/brt_usb_ss_link_sched.md
Name: brt_usb_ss_link_sched

Overview:
- Sequences the host/device pass-through interconnect of the USB SS serial test harness.
- Controls VBUS power-up, SuperSpeed receiver-termination detection with debounce and retry, and fallback to the USB 2.0 HS path.
- Handles forced disconnect/reconnect for tests.
- Its enable outputs gate the SS lane pass-through (ssrx* driven only when ss_lane_en=1), the HS termination pass-through, and the VBUS tran connection.

Parameters:
- VBUS_DLY, 16, cycles VBUS must be on before detection starts.
- DEBOUNCE, 8, consecutive cycles a termination condition must hold before it is acted on.
- DET_TIMEOUT, 1024, cycles allowed per SS detect attempt.
- MAX_ATTEMPTS, 3, failed SS attempts before HS fallback (range 1..15).
- DISC_CYCLES, 64, cycles VBUS is held off during forced disconnect.
- CW, 16, width of the internal timer.

Ports:
- clk  input  1  harness clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  link enable; 0 forces OFF.
- force_disc  input  1  single-cycle disconnect request.
- vip_ss_termination_host  input  1  host VIP SS Rx termination present.
- vip_ss_termination_device  input  1  device VIP SS Rx termination present.
- vip_hs_termination_host  input  1  host VIP HS termination present.
- vip_hs_termination_device  input  1  device VIP HS termination present.
- vbus_en  output  1  connect VBUS between host and device.
- ss_lane_en  output  1  pass SS tx→rx lanes; 0 holds ssrx* at 0 (electrical idle).
- hs_path_en  output  1  pass HS terminations and D+/D−.
- link_state  output  3  encoded FSM state.
- ss_up  output  1  one-cycle pulse on entry to SS_ACTIVE.
- attempt_cnt  output  4  failed SS detect attempts since last VBUS_WAIT.
- disc_cnt  output  8  completed disconnects, saturating at 255.

Behaviour:
- Single clock domain. rst is synchronous, active-high, and has the highest priority.
- Reset values: all outputs 0, link_state=OFF, timer=0.
- States and encodings: OFF=0, VBUS_WAIT=1, SS_DETECT=2, SS_ACTIVE=3, HS_ACTIVE=4, DISCONNECT=5. Codes 6 and 7 are illegal and recover to OFF on the next clock.
- Priority each clock: rst > enable=0 (go OFF) > force_disc (go DISCONNECT, from any state except OFF) > normal transitions.
- Timer: cleared on every state entry; increments by 1 per cycle; saturates at 2^CW−1.
- Debounce counter: separate counter; clears whenever the monitored condition is false or the state changes.
- Definitions: ss_both = vip_ss_termination_host & vip_ss_termination_device; hs_both = the same AND over the HS terminations.
- OFF: all enables 0. When enable=1, go to VBUS_WAIT next cycle.
- VBUS_WAIT: vbus_en=1 (registered, asserted the cycle the state is entered); attempt_cnt cleared. Leave for SS_DETECT when timer = VBUS_DLY−1, i.e. VBUS_DLY cycles in the state.
- SS_DETECT: vbus_en=1.
  - ss_both held for DEBOUNCE consecutive cycles → SS_ACTIVE.
  - Else if timer reaches DET_TIMEOUT−1 → attempt_cnt+1. If the new value equals MAX_ATTEMPTS → HS_ACTIVE; otherwise re-enter SS_DETECT (timer cleared).
  - If the debounce completes on the same cycle as the timeout, success wins.
- SS_ACTIVE: vbus_en=1, ss_lane_en=1; ss_up pulses on the first cycle. If ss_both is low for DEBOUNCE consecutive cycles → SS_DETECT, with attempt_cnt unchanged.
- HS_ACTIVE: vbus_en=1, hs_path_en=1. If hs_both is low for DEBOUNCE consecutive cycles → DISCONNECT. SS is not retried from HS_ACTIVE.
- DISCONNECT: all enables 0. After DISC_CYCLES cycles, disc_cnt+1 (saturating) and go to VBUS_WAIT. A force_disc arriving while already in DISCONNECT restarts the timer.
- Output timing: all outputs are registered and decode the current state. ss_lane_en and hs_path_en are never both 1.
- Glitch rule: a termination glitch shorter than DEBOUNCE cycles has no effect in any state.

Test Plan (VBUS_DLY=4, DEBOUNCE=3, DET_TIMEOUT=20, MAX_ATTEMPTS=2, DISC_CYCLES=5):
- Reset, then enable=1 with ss terminations high → link_state 0→1, vbus_en=1 at cycle 1; state 2 for 3 cycles; ss_up pulse and ss_lane_en=1 at cycle 8; attempt_cnt=0.
- Device SS termination never asserted, HS terminations high → two 20-cycle attempts (attempt_cnt 1, then 2) → HS_ACTIVE, hs_path_en=1, ss_lane_en stays 0.
- In SS_ACTIVE, drop host SS termination for 2 cycles → stays SS_ACTIVE; drop for 3 cycles → SS_DETECT, ss_lane_en=0 the next cycle.
- In SS_ACTIVE, pulse force_disc → DISCONNECT next cycle with all enables 0; 5 cycles later disc_cnt=1 and state=VBUS_WAIT; re-detect to SS_ACTIVE.
- force_disc and enable=0 in the same cycle → OFF, disc_cnt unchanged. Assert rst mid-SS_DETECT → all outputs 0 next cycle.
- Final debounce cycle coincides with timeout on the 2nd attempt → SS_ACTIVE, attempt_cnt=1, no HS fallback.
